// File: rtl/multu_hilo_unit.sv
// Iterative unsigned MULTU unit with architectural HI/LO registers, retiring BITS_PC multiplier bits per cycle.
// Optional `MULTU_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module multu_hilo_unit #(
   parameter int WIDTH   = 32,
   parameter int BITS_PC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             rd_req_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int N  = WIDTH / BITS_PC;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] partial;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_next;
   logic               finish;

   assign partial     = mcand * {{(2*WIDTH-BITS_PC){1'b0}}, mplier[BITS_PC-1:0]};
   assign acc_next    = acc + partial;
   assign mplier_next = mplier >> BITS_PC;

`ifdef MULTU_EARLY_OUT_EN
   // Once the shifted multiplier is zero every remaining partial product is zero too.
   assign finish = (count == CW'(1)) || (mplier_next == '0);
`else
   assign finish = (count == CW'(1));
`endif

   assign busy_o  = (state == RUN);
   assign stall_o = busy_o & (start_i | rd_req_i);

   // HI/LO change only at completion, so dependent reads stall until the done cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         hi_o   <= '0;
         lo_o   <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  mcand  <= {{WIDTH{1'b0}}, a_i};
                  mplier <= b_i;
                  acc    <= '0;
                  count  <= CW'(N);
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << BITS_PC;
               mplier <= mplier_next;
               count  <= count - CW'(1);
               if (finish) begin
                  {hi_o, lo_o} <= acc_next;
                  done_o       <= 1'b1;
                  count        <= '0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
